decode_sequencer: RTL and testbench
===================================

Name: decode_sequencer

Overview:
- Top-level phase controller for the image decompressor.
- After a start pulse, it launches milestone 2 (IDCT/dequant), waits for its completion, then launches milestone 1 (upsampling + colour-space conversion).
- It owns the single-port SRAM: the active milestone's address, write data and write enable are muxed onto the shared SRAM bus.
- It provides a per-phase watchdog, an abort input, done/error status and a total cycle counter.

Parameters:
- TIMEOUT_CYCLES, 24'd4000000: maximum RUN-state cycles per phase before the error state.
- ENABLE_M2, 1: 0 skips the milestone-2 phase, so only milestone 1 runs.
- GUARD_CYCLES, 2: RUN cycles after a start pulse during which the milestone's end input is ignored.

Ports:
- Clock, in, 1: system clock.
- resetn, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle request to begin decoding.
- abort, in, 1: synchronous abort to IDLE.
- m1_start, out, 1: one-cycle launch pulse to milestone 1.
- m1_end, in, 1: milestone 1 completion level.
- m1_SRAM_address, in, 18: milestone 1 address.
- m1_SRAM_write_data, in, 16: milestone 1 write data.
- m1_SRAM_we_n, in, 1: milestone 1 write enable, active low.
- m2_start, out, 1: launch pulse to milestone 2.
- m2_end, in, 1: milestone 2 completion level.
- m2_SRAM_address, in, 18: milestone 2 address.
- m2_SRAM_write_data, in, 16: milestone 2 write data.
- m2_SRAM_we_n, in, 1: milestone 2 write enable, active low.
- SRAM_address, out, 18: shared SRAM address.
- SRAM_write_data, out, 16: shared SRAM write data.
- SRAM_we_n, out, 1: shared SRAM write enable, active low.
- busy, out, 1: high in any START or RUN state.
- done, out, 1: high in S_DONE.
- error, out, 1: high in S_ERROR.
- error_phase, out, 1: 0 = milestone 2 timed out, 1 = milestone 1 timed out.
- cycle_count, out, 32: cycles of the last or current run.

Behaviour:
- States: S_IDLE, S_M2_START, S_M2_RUN, S_M1_START, S_M1_RUN, S_DONE, S_ERROR.
- Reset (asynchronous):
  - state = S_IDLE.
  - cycle_count = 0, phase timer = 0, guard counter = 0, error_phase = 0.
  - Therefore all outputs are low, except SRAM_we_n = 1, SRAM_address = 0 and SRAM_write_data = 0.
- Start acceptance:
  - start is sampled in S_IDLE, S_DONE and S_ERROR.
  - On acceptance: go to S_M2_START (or S_M1_START if ENABLE_M2 = 0), and clear cycle_count, done and error.
  - start is ignored while busy.
- START states: last exactly one cycle; the matching mX_start is 1 only in that state (decoded from the registered state). Phase timer and guard counter load 0.
- RUN states:
  - The guard counter increments for the first GUARD_CYCLES cycles; mX_end is ignored while guard < GUARD_CYCLES. This masks a stale end level left over from the previous run.
  - After the guard, mX_end = 1 moves M2_RUN to M1_START and M1_RUN to S_DONE on the next edge.
  - The phase timer increments every RUN cycle. If it reaches TIMEOUT_CYCLES-1 without a qualifying end, go to S_ERROR; error_phase is set to the phase.
  - A qualifying end in that same cycle takes priority over the timeout.
- cycle_count:
  - Increments by 1 in every START or RUN cycle; saturates at 32'hFFFFFFFF.
  - Holds its value in IDLE, DONE and ERROR.
- SRAM mux (combinational from the registered state):
  - M2_START/M2_RUN: m2 signals pass through.
  - M1_START/M1_RUN: m1 signals pass through.
  - Otherwise: address 0, data 0, we_n 1. No write can ever leak from an idle milestone.
- abort:
  - In any non-IDLE state, the next state is S_IDLE and no start pulse is issued. done and error clear; cycle_count holds.
  - abort has priority over start, end and timeout in the same cycle.
- Reset mid-run: immediate return to S_IDLE; the SRAM bus is released (we_n = 1) asynchronously.

Test Plan:
1. Normal run.
   - Stimulus: ENABLE_M2 = 1. The model raises m2_end 100 cycles after the m2_start cycle and m1_end 200 cycles after the m1_start cycle.
   - Required: m2_start is a single 1-cycle pulse, then m1_start is a single pulse 101 cycles later. done = 1, busy = 0, cycle_count = 302.
2. Stale end.
   - Stimulus: m1_end and m2_end are held high from the previous run and drop 1 cycle after their start pulses.
   - Required: no early phase exit; the final cycle_count still equals the count from scenario 1 for the same delays.
3. Timeout.
   - Stimulus: TIMEOUT_CYCLES = 50, m2_end never rises.
   - Required: error = 1 and error_phase = 0 after exactly 50 M2_RUN cycles. m1_start never pulses. SRAM_we_n = 1 in S_ERROR. A subsequent start restarts cleanly.
4. Mux isolation.
   - Stimulus: during M1_RUN, m1 drives address 18'd146944, data 16'hABCD, we_n 0, while m2 drives address 18'd5 with we_n 0.
   - Required: the SRAM outputs equal the m1 values. In S_DONE: address 0, we_n 1.
5. Abort and busy-start.
   - Stimulus: start pulsed during M1_RUN, then abort during M1_RUN.
   - Required: the start has no effect. The next state after abort is S_IDLE; busy = 0, done = 0; cycle_count is frozen.
   - Stimulus: resetn asserted low mid-M2_RUN.
   - Required: immediate idle.
6. ENABLE_M2 = 0.
   - Stimulus: start, with m1_end raised 10 cycles after m1_start.
   - Required: m2_start is never asserted, done = 1, cycle_count = 11.

Source files
------------

// File: rtl/decode_sequencer.sv
// Top-level phase controller for the image decompressor: launches milestone 2 then
// milestone 1, owns the shared SRAM bus, and reports done/error/cycle count.
module decode_sequencer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000,
    parameter bit          ENABLE_M2      = 1'b1,
    parameter int unsigned GUARD_CYCLES   = 2
) (
    input  logic        Clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    output logic        m1_start,
    input  logic        m1_end,
    input  logic [17:0] m1_SRAM_address,
    input  logic [15:0] m1_SRAM_write_data,
    input  logic        m1_SRAM_we_n,
    output logic        m2_start,
    input  logic        m2_end,
    input  logic [17:0] m2_SRAM_address,
    input  logic [15:0] m2_SRAM_write_data,
    input  logic        m2_SRAM_we_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        error_phase,
    output logic [31:0] cycle_count
);

    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_M2_START,
        S_M2_RUN,
        S_M1_START,
        S_M1_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   timer_q, timer_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          err_ph_q, err_ph_d;
    logic [31:0]   count_q, count_d;

    logic run, guard_ok, end_in, end_ok, tmo;

    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            guard_q  <= '0;
            err_ph_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            guard_q  <= guard_d;
            err_ph_q <= err_ph_d;
            count_q  <= count_d;
        end
    end

    // Guard masks an end level still high from the previous run.
    assign run      = (state_q == S_M2_RUN) || (state_q == S_M1_RUN);
    assign guard_ok = 32'(guard_q) >= GUARD_CYCLES;
    assign end_in   = (state_q == S_M2_RUN) ? m2_end : m1_end;
    assign end_ok   = run && guard_ok && end_in;
    assign tmo      = run && (timer_q == TIMEOUT_CYCLES - 24'd1);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        guard_d  = guard_q;
        err_ph_d = err_ph_q;
        count_d  = count_q;

        if (busy && count_q != 32'hFFFF_FFFF)
            count_d = count_q + 32'd1;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = ENABLE_M2 ? S_M2_START : S_M1_START;
                    count_d = '0;
                end
            end
            S_M2_START, S_M1_START: begin
                state_d = (state_q == S_M2_START) ? S_M2_RUN : S_M1_RUN;
                timer_d = '0;
                guard_d = '0;
            end
            S_M2_RUN, S_M1_RUN: begin
                timer_d = timer_q + 24'd1;
                if (!guard_ok)
                    guard_d = guard_q + GW'(1);
                if (end_ok) begin
                    state_d = (state_q == S_M2_RUN) ? S_M1_START : S_DONE;
                end else if (tmo) begin
                    state_d  = S_ERROR;
                    err_ph_d = (state_q == S_M1_RUN);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over start, end and timeout; the count freezes where it stood.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            count_d = count_q;
        end
    end

    assign m2_start    = (state_q == S_M2_START);
    assign m1_start    = (state_q == S_M1_START);
    assign busy        = (state_q == S_M2_START) || (state_q == S_M2_RUN) ||
                         (state_q == S_M1_START) || (state_q == S_M1_RUN);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERROR);
    assign error_phase = err_ph_q;
    assign cycle_count = count_q;

    // Bus is decoded from the registered state so reset releases it immediately.
    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (state_q)
            S_M2_START, S_M2_RUN: begin
                SRAM_address    = m2_SRAM_address;
                SRAM_write_data = m2_SRAM_write_data;
                SRAM_we_n       = m2_SRAM_we_n;
            end
            S_M1_START, S_M1_RUN: begin
                SRAM_address    = m1_SRAM_address;
                SRAM_write_data = m1_SRAM_write_data;
                SRAM_we_n       = m1_SRAM_we_n;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench: instance 0 default, instance 1 short timeout, instance 2 without milestone 2.
module tb_decode_sequencer;

    logic Clock = 1'b0;
    logic resetn = 1'b0;
    always #5 Clock = ~Clock;

    logic [2:0] st = '0, ab = '0, m1e = '0, m2e = '0;
    logic [2:0] m1s, m2s, busy, done, err, ep, we;
    logic [2:0][17:0] addr;
    logic [2:0][15:0] wd;
    logic [2:0][31:0] cnt;
    logic [17:0] m1a = '0, m2a = '0;
    logic [15:0] m1d = '0, m2d = '0;
    logic        m1w = 1'b1, m2w = 1'b1;

    int n_tests = 0, n_fail = 0;

    decode_sequencer u0 (
        .Clock(Clock), .resetn(resetn), .start(st[0]), .abort(ab[0]),
        .m1_start(m1s[0]), .m1_end(m1e[0]), .m1_SRAM_address(m1a), .m1_SRAM_write_data(m1d),
        .m1_SRAM_we_n(m1w), .m2_start(m2s[0]), .m2_end(m2e[0]), .m2_SRAM_address(m2a),
        .m2_SRAM_write_data(m2d), .m2_SRAM_we_n(m2w), .SRAM_address(addr[0]),
        .SRAM_write_data(wd[0]), .SRAM_we_n(we[0]), .busy(busy[0]), .done(done[0]),
        .error(err[0]), .error_phase(ep[0]), .cycle_count(cnt[0]));

    decode_sequencer #(.TIMEOUT_CYCLES(24'd50)) u1 (
        .Clock(Clock), .resetn(resetn), .start(st[1]), .abort(ab[1]),
        .m1_start(m1s[1]), .m1_end(m1e[1]), .m1_SRAM_address(m1a), .m1_SRAM_write_data(m1d),
        .m1_SRAM_we_n(m1w), .m2_start(m2s[1]), .m2_end(m2e[1]), .m2_SRAM_address(m2a),
        .m2_SRAM_write_data(m2d), .m2_SRAM_we_n(m2w), .SRAM_address(addr[1]),
        .SRAM_write_data(wd[1]), .SRAM_we_n(we[1]), .busy(busy[1]), .done(done[1]),
        .error(err[1]), .error_phase(ep[1]), .cycle_count(cnt[1]));

    decode_sequencer #(.ENABLE_M2(1'b0)) u2 (
        .Clock(Clock), .resetn(resetn), .start(st[2]), .abort(ab[2]),
        .m1_start(m1s[2]), .m1_end(m1e[2]), .m1_SRAM_address(m1a), .m1_SRAM_write_data(m1d),
        .m1_SRAM_we_n(m1w), .m2_start(m2s[2]), .m2_end(m2e[2]), .m2_SRAM_address(m2a),
        .m2_SRAM_write_data(m2d), .m2_SRAM_we_n(m2w), .SRAM_address(addr[2]),
        .SRAM_write_data(wd[2]), .SRAM_we_n(we[2]), .busy(busy[2]), .done(done[2]),
        .error(err[2]), .error_phase(ep[2]), .cycle_count(cnt[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Inputs driven at step k are what the DUT samples at the end of cycle k.
    task automatic run_normal(input string tg, input bit stale);
        int s1, n1, n2, dn;
        s1 = -1; n1 = 0; n2 = 0; dn = -1;
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (m2s[0]) n2++;
            if (m1s[0]) begin n1++; if (s1 < 0) s1 = k; end
            if (done[0]) begin dn = k; break; end
            if (k == 50) begin
                m2a = 18'd5; m2d = 16'h1111; m2w = 1'b0; m1a = 18'd9; m1w = 1'b0; #1;
                chk({tg, "_m2_addr"}, 32'(addr[0]), 32'd5);
                chk({tg, "_m2_data"}, 32'(wd[0]), 32'h1111);
                chk({tg, "_m2_we"}, 32'(we[0]), 32'd0);
            end
            if (k == 150) begin
                m1a = 18'd146944; m1d = 16'hABCD; m1w = 1'b0; m2a = 18'd5; m2w = 1'b0; #1;
                chk({tg, "_m1_addr"}, 32'(addr[0]), 32'd146944);
                chk({tg, "_m1_data"}, 32'(wd[0]), 32'hABCD);
                chk({tg, "_m1_we"}, 32'(we[0]), 32'd0);
            end
            m2e[0] = (stale && k <= 1) || (k >= 100);
            m1e[0] = (s1 < 0) ? stale : ((stale && k <= s1 + 1) || (k >= s1 + 200));
            tick();
        end
        chk({tg, "_m2_pulses"}, 32'(n2), 32'd1);
        chk({tg, "_m1_idx"}, 32'(s1), 32'd101);
        chk({tg, "_m1_pulses"}, 32'(n1), 32'd1);
        chk({tg, "_done_idx"}, 32'(dn), 32'd302);
        chk({tg, "_count"}, cnt[0], 32'd302);
        chk({tg, "_busy"}, 32'(busy[0]), 32'd0);
        chk({tg, "_done_addr"}, 32'(addr[0]), 32'd0);
        chk({tg, "_done_we"}, 32'(we[0]), 32'd1);
    endtask

    // m2_delay == 0 means m2_end never rises.
    task automatic run_tmo(input int m2_delay, output int idx, output int n1);
        idx = -1; n1 = 0;
        st[1] = 1'b1; tick(); st[1] = 1'b0;
        chk("tmo_m2_start", 32'(m2s[1]), 32'd1);
        chk("tmo_err_clear", 32'(err[1]), 32'd0);
        chk("tmo_count_clear", cnt[1], 32'd0);
        for (int k = 0; k < 200; k++) begin
            if (m1s[1]) n1++;
            if (err[1]) begin idx = k; break; end
            m2e[1] = (m2_delay > 0) && (k >= m2_delay);
            tick();
        end
    endtask

    initial begin
        int idx, n1, n2, dn;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_we", 32'(we), 32'd7);
        chk("rst_addr", 32'(addr[0]), 32'd0);
        chk("rst_count", cnt[0], 32'd0);
        resetn = 1'b1;
        tick(); tick();

        run_normal("normal", 1'b0);
        tick(); tick();
        run_normal("stale", 1'b1);

        // Timeout in milestone 2, then a clean restart that times out in milestone 1.
        run_tmo(0, idx, n1);
        chk("tmo2_idx", 32'(idx), 32'd51);
        chk("tmo2_phase", 32'(ep[1]), 32'd0);
        chk("tmo2_we", 32'(we[1]), 32'd1);
        chk("tmo2_count", cnt[1], 32'd51);
        chk("tmo2_no_m1", 32'(n1), 32'd0);
        chk("tmo2_busy", 32'(busy[1]), 32'd0);
        run_tmo(10, idx, n1);
        chk("tmo1_idx", 32'(idx), 32'd62);
        chk("tmo1_phase", 32'(ep[1]), 32'd1);
        chk("tmo1_count", cnt[1], 32'd62);
        chk("tmo1_m1_pulses", 32'(n1), 32'd1);

        // Milestone 2 disabled.
        n2 = 0; dn = -1;
        st[2] = 1'b1; tick(); st[2] = 1'b0;
        chk("m1only_start", 32'(m1s[2]), 32'd1);
        for (int k = 0; k < 100; k++) begin
            if (m2s[2]) n2++;
            if (done[2]) begin dn = k; break; end
            m1e[2] = (k >= 10);
            tick();
        end
        chk("m1only_done_idx", 32'(dn), 32'd11);
        chk("m1only_count", cnt[2], 32'd11);
        chk("m1only_no_m2", 32'(n2), 32'd0);

        // Busy start is ignored, then abort mid M1_RUN.
        m1e[0] = 1'b0; m2e[0] = 1'b0; m1w = 1'b1; m2w = 1'b1;
        tick();
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        for (int k = 0; k < 120; k++) begin
            st[0] = (k == 110);
            if (k == 115) begin
                chk("busy_start_busy", 32'(busy[0]), 32'd1);
                chk("busy_start_no_pulse", 32'(m1s[0] | m2s[0]), 32'd0);
            end
            m2e[0] = (k >= 100);
            tick();
        end
        st[0] = 1'b0;
        ab[0] = 1'b1; tick(); ab[0] = 1'b0;
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_done", 32'(done[0]), 32'd0);
        chk("abort_err", 32'(err[0]), 32'd0);
        chk("abort_count", cnt[0], 32'd120);
        for (int k = 0; k < 5; k++) tick();
        chk("abort_count_frozen", cnt[0], 32'd120);
        chk("abort_still_idle", 32'(busy[0] | m1s[0] | m2s[0]), 32'd0);

        // Asynchronous reset in M2_RUN releases the bus without a clock edge.
        m2e[0] = 1'b0;
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        m2a = 18'd7; m2w = 1'b0; #1;
        chk("pre_rst_we", 32'(we[0]), 32'd0);
        resetn = 1'b0; #1;
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_we", 32'(we[0]), 32'd1);
        chk("midrst_addr", 32'(addr[0]), 32'd0);
        chk("midrst_count", cnt[0], 32'd0);
        tick(); resetn = 1'b1; tick();
        chk("post_rst_idle", 32'(busy[0] | done[0] | err[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
